// File: rtl/aes_128_pkg.sv
// Shared AES-128 constants, state encoding and GF(2^8) helpers for the encryptor and decryptor.
// Byte 0 of a 128-bit block sits in bits [127:120]; bytes fill the state column by column.
package aes_128_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {StIdle, StKeyExp, StDec} aes_dec_state_t;

  localparam logic [0:255][7:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    256'h52096ad53036a538bf40a39e81f3d7fb_7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e_082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b692_6c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506_d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e673_96ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1b_fc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f_60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961_172b047eba77d626e169146355210c7d
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Indices outside 1..10 only occur in cycles where the key step output is unused.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) return RCON[r];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r) & 3) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_128_key_step.sv
// One AES-128 key schedule step, forward (rk_r -> rk_r+1) or inverse (rk_r -> rk_r-1).
// The inverse direction expects the Rcon that produced rk_in.
module aes_128_key_step import aes_128_pkg::*; (
  input  logic [127:0] rk_in,
  input  logic [7:0]   rcon,
  input  logic         dir,
  output logic [127:0] rk_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = rk_in[127:96];
  assign w1 = rk_in[95:64];
  assign w2 = rk_in[63:32];
  assign w3 = rk_in[31:0];

  always_comb begin
    n0 = '0;
    n1 = '0;
    n2 = '0;
    n3 = '0;
    if (!dir) begin
      n0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end else begin
      // Recover the previous words back to front; the first word needs the previous w3.
      n3 = w3 ^ w2;
      n2 = w2 ^ w1;
      n1 = w1 ^ w0;
      n0 = w0 ^ sub_word(rot_word(n3)) ^ {rcon, 24'h000000};
    end
    rk_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_128_dec.sv
// Multicycle AES-128 decryptor: forward key expansion to rk10, then ten inverse rounds while
// walking the key schedule back to rk0. One block per 21 cycles.
module aes_128_dec import aes_128_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_bus,
  input  logic [127:0] key,
  input  logic         start,
  output logic [127:0] out_bus,
  output logic         ready,
  output logic         valid
);

  aes_dec_state_t fsm_q;
  logic [3:0]     rnd_q;
  logic [127:0]   state_q;
  logic [127:0]   rk_q;
  logic [127:0]   out_q;
  logic           ready_q;
  logic           valid_q;

  logic [3:0]     rcon_idx;
  logic           key_dir;
  logic [127:0]   key_next;
  logic [127:0]   inv_core;
  logic [127:0]   final_out;
  logic [127:0]   round_out;

  // In DEC the step undoes the expansion that used Rcon[rnd + 1].
  always_comb begin
    key_dir  = (fsm_q == StDec);
    rcon_idx = key_dir ? (rnd_q + 4'd1) : rnd_q;
  end

  aes_128_key_step u_key_step (
    .rk_in  (rk_q),
    .rcon   (rcon_of(rcon_idx)),
    .dir    (key_dir),
    .rk_out (key_next)
  );

  always_comb begin
    inv_core  = inv_sub_bytes(inv_shift_rows(state_q));
    final_out = inv_core ^ key_next;
    round_out = inv_mix_columns(final_out);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      rnd_q   <= 4'd0;
      state_q <= '0;
      rk_q    <= '0;
      out_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (fsm_q)
        StIdle: begin
          if (start) begin
            state_q <= in_bus;
            rk_q    <= key;
            rnd_q   <= 4'd1;
            ready_q <= 1'b0;
            fsm_q   <= StKeyExp;
          end
        end
        StKeyExp: begin
          rk_q <= key_next;
          if (rnd_q == 4'(NR)) begin
            state_q <= state_q ^ key_next;
            rnd_q   <= 4'(NR - 1);
            fsm_q   <= StDec;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        StDec: begin
          if (rnd_q == 4'd0) begin
            out_q   <= final_out;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            fsm_q   <= StIdle;
          end else begin
            state_q <= round_out;
            rk_q    <= key_next;
            rnd_q   <= rnd_q - 4'd1;
          end
        end
        default: begin
          fsm_q   <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_bus = out_q;
  assign ready   = ready_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_aes_128_dec.sv
// Directed bench for aes_128_dec: known-answer table plus scrambled-input, back-to-back and
// mid-run reset sequences.
module tb_aes_128_dec;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] in_bus;
  logic [127:0] key;
  logic [127:0] out_bus;
  logic         ready;
  logic         valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_128_dec dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_bus  (in_bus),
    .key     (key),
    .start   (start),
    .out_bus (out_bus),
    .ready   (ready),
    .valid   (valid)
  );

  typedef struct {
    string        name;
    logic [127:0] k;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [5];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge while idle; the request is taken on the next rising edge.
  task automatic accept(input string name, input logic [127:0] k, input logic [127:0] ct);
    check({name, "_ready_at_accept"}, 128'(ready), 128'd1);
    in_bus = ct;
    key    = k;
    start  = 1'b1;
    @(negedge clk);
  endtask

  // Starts one falling edge after the accept edge; returns at the falling edge of the valid cycle.
  task automatic track(input string name, input logic [127:0] exp, input bit scramble,
                       input bit chk_rk, input logic [127:0] rk10);
    int busy_bad;
    busy_bad = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (ready !== 1'b0 || valid !== 1'b0) busy_bad++;
      if (chk_rk && cyc == 10) check({name, "_rk10"}, dut.rk_q, rk10);
      if (scramble) begin
        in_bus = rand128();
        key    = rand128();
        start  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_busy_window"}, 128'(busy_bad), 128'd0);
    check({name, "_valid_at_20"}, 128'(valid), 128'd1);
    check({name, "_ready_at_20"}, 128'(ready), 128'd1);
    check({name, "_out"}, out_bus, exp);
  endtask

  task automatic idle_after(input string name, input logic [127:0] exp);
    @(negedge clk);
    check({name, "_valid_drops"}, 128'(valid), 128'd0);
    check({name, "_out_holds"}, out_bus, exp);
  endtask

  initial begin
    int stray;

    vecs[0] = '{"c1", C1_KEY, C1_CT, C1_PT};
    vecs[1] = '{"appb", B_KEY, B_CT, B_PT};
    vecs[2] = '{"zero", 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
    vecs[3] = '{"ecb1", B_KEY, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[4] = '{"ecb2", B_KEY, 128'hf5d3d58503b9699de785895a96fdbaaf,
                128'hae2d8a571e03ac9c9eb76fac45af8e51};

    rst_n  = 1'b0;
    start  = 1'b0;
    in_bus = '0;
    key    = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 128'(ready), 128'd1);
    check("reset_valid", 128'(valid), 128'd0);
    check("reset_out", out_bus, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      accept(vecs[i].name, vecs[i].k, vecs[i].ct);
      track(vecs[i].name, vecs[i].pt, 1'b0, 1'b0, 128'd0);
      idle_after(vecs[i].name, vecs[i].pt);
    end

    // Inputs toggle freely while busy; start pulses must be ignored.
    accept("c1_scr", C1_KEY, C1_CT);
    track("c1_scr", C1_PT, 1'b1, 1'b0, 128'd0);
    idle_after("c1_scr", C1_PT);
    accept("appb_scr", B_KEY, B_CT);
    track("appb_scr", B_PT, 1'b1, 1'b1, B_RK10);
    idle_after("appb_scr", B_PT);

    // Second request lands in the valid cycle of the first.
    accept("b2b_first", C1_KEY, C1_CT);
    track("b2b_first", C1_PT, 1'b0, 1'b0, 128'd0);
    accept("b2b_second", B_KEY, B_CT);
    track("b2b_second", B_PT, 1'b0, 1'b0, 128'd0);
    idle_after("b2b_second", B_PT);

    // Reset twelve cycles into a run: the block is dropped and outputs clear.
    accept("rst_run", C1_KEY, C1_CT);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", 128'(ready), 128'd1);
    check("midrst_out", out_bus, 128'd0);
    check("midrst_valid", 128'(valid), 128'd0);
    rst_n = 1'b1;
    stray = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (valid !== 1'b0) stray++;
      @(negedge clk);
    end
    check("midrst_no_stray_valid", 128'(stray), 128'd0);
    accept("post_rst", C1_KEY, C1_CT);
    track("post_rst", C1_PT, 1'b0, 1'b0, 128'd0);
    idle_after("post_rst", C1_PT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_128_dec.md
# aes_128_dec

Multicycle AES-128 decryptor (FIPS-197 inverse cipher), the receive-side counterpart of the multicycle `aes_128` encryptor. It accepts a 128-bit ciphertext block and the original cipher key, not a pre-expanded decryption key. It runs a forward key expansion, then ten inverse rounds while regressing the key schedule backwards, and returns the plaintext. Byte order and bus widths match `aes_128`, so `aes_128_dec(aes_128(p, k), k) == p`.

## Interface
- No parameters; `NR` = 10 rounds, fixed in the package.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_bus`  in  128  ciphertext; bits [127:120] are byte 0 (FIPS-197 column-major order).
- `key`  in  128  cipher key, same byte order as `in_bus`.
- `start`  in  1  request strobe; sampled only while `ready` = 1.
- `out_bus`  out  128  plaintext, registered.
- `ready`  out  1  high in IDLE; block accepts `start`.
- `valid`  out  1  one-cycle pulse; `out_bus` holds a new result.

## Operation
- States: IDLE, KEYEXP, DEC. Round counter `rnd` is 4 bits.
- IDLE:
  - `start` = 1 latches `in_bus` into `state_q` and `key` into `rk_q`.
  - Sets `rnd` = 1 and moves to KEYEXP.
- KEYEXP, `rnd` = 1..10:
  - `rk_q` <= KeyExpand(`rk_q`, Rcon[`rnd`]).
  - At `rnd` = 10, also `state_q` <= `state_q` ^ rk10.
  - Then sets `rnd` = 9 and moves to DEC.
- DEC, `rnd` = 9..1:
  - `state_q` <= InvMixColumns(InvSubBytes(InvShiftRows(`state_q`)) ^ rk_`rnd`).
  - `rk_q` regresses: rk_{r-1} from rk_r, using w[i-4] = w[i] ^ f(w[i-1]) for the first word and w[i-4] = w[i] ^ w[i-1] otherwise, with Rcon[`rnd`+1].
- DEC, `rnd` = 0 (final round):
  - `state_q` is not updated.
  - `out_bus` <= InvSubBytes(InvShiftRows(`state_q`)) ^ rk0.
  - `valid` <= 1; return to IDLE.
- Inputs `in_bus`, `key` and `start` are don't-care outside the IDLE accept cycle. Random toggling of them mid-operation must not affect the result.
- `start` while `ready` = 0 is ignored. It is not queued.
- `out_bus` holds its value until the next result or reset.
- Reset, including mid-operation:
  - Next cycle is IDLE with `out_bus` = 0, `valid` = 0, `ready` = 1.
  - Any in-flight block is discarded and never reported.
- Arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns multiplies by {0e,0b,0d,09}.

## Timing
- Accept edge E0: `ready` = 1 and `start` = 1.
- KEYEXP occupies edges E1..E10; DEC occupies edges E11..E20.
- `valid` = 1 and new `out_bus` appear in the cycle after E20. Latency is 20 cycles from accept to `valid`.
- `ready` is low from the cycle after E0 until `valid`.
- `ready` returns to 1 in the same cycle as `valid`. A `start` in that cycle is accepted, giving back-to-back throughput of one block per 21 cycles.
- Reset values: `out_bus` = 128'h0, `valid` = 0, `ready` = 1. Internal registers are cleared to 0.

## Structure
- Package `aes_128_pkg` holds:
  - `SBOX[256]`, `INV_SBOX[256]`, `RCON[1:10]`.
  - State enum `aes_dec_state_t`.
  - Functions `xtime`, `gmul`, `sub_word`, `rot_word`, `inv_shift_rows`, `inv_mix_columns`.
  - The encryptor imports the same package.
- Sub-module `aes_128_key_step` (combinational):
  - Inputs: `rk_in[127:0]`, `rcon[7:0]`, `dir` (0 = forward, 1 = inverse).
  - Output: `rk_out[127:0]`.
  - Single instance, used in both KEYEXP and DEC.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> `out_bus` = 00112233445566778899aabbccddeeff, `valid` exactly 20 cycles after accept.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734. Internal rk10 must equal d014f9a8c9ee2589e13f0cc8b6630ca6 at the end of KEYEXP.
- Randomize `in_bus`, `key` and `start` every cycle during both vectors above -> identical results, `ready` low throughout, no extra `valid` pulses.
- Back-to-back: `start` asserted in the `valid` cycle of the C.1 block with the Appendix B inputs -> second `valid` 21 cycles after the first, both results correct.
- Pull `rst_n` low at cycle 12 of a C.1 run -> next cycle `ready` = 1, `out_bus` = 0, no `valid`. A fresh C.1 request then completes correctly.
- Round trip: feed 1000 random (p, k) pairs through `aes_128`, then through `aes_128_dec` -> recovered p matches every time; write results to `output.txt`.
